// File: rtl/load_pkg.sv
// load_pkg
//   Shared definitions for the load alignment unit: the RISC-V load funct3
//   encodings, the load FSM states and two helpers that decode funct3 into
//   an access size and into legality for a given data width.
package load_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'b000,
    OP_LH  = 3'b001,
    OP_LW  = 3'b010,
    OP_LD  = 3'b011,
    OP_LBU = 3'b100,
    OP_LHU = 3'b101,
    OP_LWU = 3'b110
  } load_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BEAT0,
    ST_BEAT1,
    ST_RESP
  } load_state_e;

  localparam int RD_W = 5;

  // The low two funct3 bits encode log2 of the access size for every load
  function automatic logic [3:0] load_size(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      2'b10:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  // LD and LWU only exist on RV64; 3'b111 is never a load
  function automatic logic load_legal(input logic [2:0] funct3, input int xlen);
    case (load_op_e'(funct3))
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: return 1'b1;
      OP_LD, OP_LWU:                       return (xlen == 64);
      default:                             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extract.sv
// load_extract
//   Combinational byte selection and extension for loads. The two memory
//   beats are treated as one double-width little-endian window, shifted down
//   by the byte offset, and the low 'size' bytes are sign- or zero-extended.
// Ports:
//   beat0  - word at the aligned address
//   beat1  - following word (zero for single-beat loads)
//   off    - byte offset of the load within beat0
//   funct3 - load type (size in bits [1:0], unsigned when bit 2 is set)
//   data   - extended result
module load_extract
  import load_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]            beat0,
  input  logic [XLEN-1:0]            beat1,
  input  logic [$clog2(XLEN/8)-1:0]  off,
  input  logic [2:0]                 funct3,
  output logic [XLEN-1:0]            data
);

  logic [XLEN-1:0] window;
  logic            is_signed;

  // Shift the addressed bytes to bit 0, then extend according to size/sign
  always_comb begin
    window    = XLEN'({beat1, beat0} >> {off, 3'b000});
    is_signed = ~funct3[2];
    data      = window;
    case (load_size(funct3))
      4'd1: begin
        if (is_signed) data = XLEN'($signed(window[7:0]));
        else           data = XLEN'(window[7:0]);
      end
      4'd2: begin
        if (is_signed) data = XLEN'($signed(window[15:0]));
        else           data = XLEN'(window[15:0]);
      end
      4'd4: begin
        if (is_signed) data = XLEN'($signed(window[31:0]));
        else           data = XLEN'(window[31:0]);
      end
      default: data = window;
    endcase
  end

endmodule

// File: rtl/load_align_unit.sv
// load_align_unit
//   Multi-cycle load unit. Accepts one load at a time, reads word-aligned
//   data over a req/ack memory handshake, extracts and extends the addressed
//   bytes and returns the result (or a fault) over a valid/ready handshake.
// Configuration macro:
//   LOAD_MISALIGN_EN - when defined, misaligned loads are legal and loads
//                      crossing a word boundary use two memory beats; when
//                      undefined, misaligned loads fault without a memory read.
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   req_valid/req_ready        - request handshake from execute
//   req_funct3/req_addr/req_rd - load type, byte address, destination tag
//   mem_req/mem_addr           - word-aligned read request, held until ack
//   mem_ack/mem_rdata/mem_err  - read completion, data and bus error
//   rsp_valid/rsp_ready        - response handshake
//   rsp_data/rsp_rd/rsp_fault  - extended result, echoed tag, fault flag
module load_align_unit
  import load_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [RD_W-1:0]   req_rd,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_err,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_data,
  output logic [RD_W-1:0]   rsp_rd,
  output logic              rsp_fault
);

  localparam int BYTES = XLEN / 8;
  localparam int OFF_W = $clog2(BYTES);

  load_state_e       state, next_state;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [RD_W-1:0]   rd_q;
  logic [OFF_W-1:0]  off_q;
  logic [ADDR_W-1:0] aligned_addr;
  logic              req_legal;

  logic              latch_req;
  logic              rsp_load;
  logic              rsp_fault_d;
  logic [XLEN-1:0]   rsp_data_d;
  logic [XLEN-1:0]   ext_beat0;
  logic [XLEN-1:0]   ext_beat1;
  logic [XLEN-1:0]   ext_data;

  assign off_q        = addr_q[OFF_W-1:0];
  assign aligned_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign req_legal    = load_legal(req_funct3, XLEN);

`ifdef LOAD_MISALIGN_EN
  logic [XLEN-1:0] beat0_q;
  logic            save_beat0;
  logic            q_cross;

  assign q_cross = (5'(off_q) + 5'(load_size(f3_q))) > 5'(BYTES);
`else
  logic [3:0] req_size;
  logic       req_misaligned;

  assign req_size       = load_size(req_funct3);
  assign req_misaligned = (req_addr[OFF_W-1:0] & OFF_W'(req_size - 4'd1)) != '0;
`endif

  // Handshake outputs follow the state directly, so an asynchronous reset
  // drops mem_req immediately and abandons any outstanding beat
  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign rsp_rd    = rd_q;

  // Memory request and address: only driven while a beat is outstanding
  always_comb begin
    mem_req  = 1'b0;
    mem_addr = '0;
    case (state)
      ST_BEAT0: begin
        mem_req  = 1'b1;
        mem_addr = aligned_addr;
      end
`ifdef LOAD_MISALIGN_EN
      ST_BEAT1: begin
        mem_req  = 1'b1;
        mem_addr = aligned_addr + ADDR_W'(BYTES);
      end
`endif
      default: ;
    endcase
  end

  // The extractor sees the live read word as beat0 on a single-beat load,
  // and the saved low word plus the live high word on the second beat
  always_comb begin
    ext_beat0 = mem_rdata;
    ext_beat1 = '0;
`ifdef LOAD_MISALIGN_EN
    if (state == ST_BEAT1) begin
      ext_beat0 = beat0_q;
      ext_beat1 = mem_rdata;
    end
`endif
  end

  load_extract #(.XLEN(XLEN)) u_extract (
    .beat0  (ext_beat0),
    .beat1  (ext_beat1),
    .off    (off_q),
    .funct3 (f3_q),
    .data   (ext_data)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state and control decode; faulting paths load a zero result
  always_comb begin
    next_state  = state;
    latch_req   = 1'b0;
    rsp_load    = 1'b0;
    rsp_fault_d = 1'b0;
    rsp_data_d  = '0;
`ifdef LOAD_MISALIGN_EN
    save_beat0  = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          latch_req = 1'b1;
          if (!req_legal) begin
            rsp_load    = 1'b1;
            rsp_fault_d = 1'b1;
            next_state  = ST_RESP;
          end
`ifndef LOAD_MISALIGN_EN
          else if (req_misaligned) begin
            rsp_load    = 1'b1;
            rsp_fault_d = 1'b1;
            next_state  = ST_RESP;
          end
`endif
          else begin
            next_state = ST_BEAT0;
          end
        end
      end
      ST_BEAT0: begin
        if (mem_ack) begin
          if (mem_err) begin
            rsp_load    = 1'b1;
            rsp_fault_d = 1'b1;
            next_state  = ST_RESP;
          end
`ifdef LOAD_MISALIGN_EN
          else if (q_cross) begin
            save_beat0 = 1'b1;
            next_state = ST_BEAT1;
          end
`endif
          else begin
            rsp_load   = 1'b1;
            rsp_data_d = ext_data;
            next_state = ST_RESP;
          end
        end
      end
`ifdef LOAD_MISALIGN_EN
      ST_BEAT1: begin
        if (mem_ack) begin
          rsp_load   = 1'b1;
          next_state = ST_RESP;
          if (mem_err) rsp_fault_d = 1'b1;
          else         rsp_data_d  = ext_data;
        end
      end
`endif
      ST_RESP: begin
        if (rsp_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Request capture and response registers; the response holds until taken
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f3_q      <= '0;
      addr_q    <= '0;
      rd_q      <= '0;
      rsp_data  <= '0;
      rsp_fault <= 1'b0;
    end else begin
      if (latch_req) begin
        f3_q   <= req_funct3;
        addr_q <= req_addr;
        rd_q   <= req_rd;
      end
      if (rsp_load) begin
        rsp_data  <= rsp_data_d;
        rsp_fault <= rsp_fault_d;
      end
    end
  end

`ifdef LOAD_MISALIGN_EN
  // Low word of a crossing load, kept while the second beat is fetched
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           beat0_q <= '0;
    else if (save_beat0) beat0_q <= mem_rdata;
  end
`endif

endmodule

// File: tb/tb_load_align_unit.sv
// tb_load_align_unit
//   Directed bench for load_align_unit: a 32-bit instance for most loads and
//   a 64-bit instance for LD. Inputs are driven and outputs sampled on the
//   falling clock edge.
module tb_load_align_unit;
  import load_pkg::*;

  logic        clk = 1'b0;
  logic        reset;

  logic        req_valid, req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [4:0]  req_rd;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_fault;

  logic        w_req_valid, w_req_ready;
  logic [2:0]  w_req_funct3;
  logic [31:0] w_req_addr;
  logic [4:0]  w_req_rd;
  logic        w_mem_req;
  logic [31:0] w_mem_addr;
  logic        w_mem_ack;
  logic [63:0] w_mem_rdata;
  logic        w_mem_err;
  logic        w_rsp_valid, w_rsp_ready;
  logic [63:0] w_rsp_data;
  logic [4:0]  w_rsp_rd;
  logic        w_rsp_fault;

  int checks = 0;
  int errors = 0;

  // Results of the most recent run_load transaction
  logic [31:0] r_data;
  logic        r_fault;
  logic [4:0]  r_rd;
  int          r_cycle;
  int          r_beats;
  logic [31:0] r_addr0, r_addr1;

  always #5 clk = ~clk;

  load_align_unit #(.XLEN(32), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_rd(req_rd),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .mem_err(mem_err),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_rd(rsp_rd), .rsp_fault(rsp_fault)
  );

  load_align_unit #(.XLEN(64), .ADDR_W(32)) dut64 (
    .clk(clk), .reset(reset),
    .req_valid(w_req_valid), .req_ready(w_req_ready), .req_funct3(w_req_funct3),
    .req_addr(w_req_addr), .req_rd(w_req_rd),
    .mem_req(w_mem_req), .mem_addr(w_mem_addr), .mem_ack(w_mem_ack),
    .mem_rdata(w_mem_rdata), .mem_err(w_mem_err),
    .rsp_valid(w_rsp_valid), .rsp_ready(w_rsp_ready), .rsp_data(w_rsp_data),
    .rsp_rd(w_rsp_rd), .rsp_fault(w_rsp_fault)
  );

  // Issues one load, acts as memory (waits cycles before each ack, error on
  // beat err_beat, words w0/w1 for beats 0/1), records the response and
  // completes the response handshake. Cycle 1 is the cycle after acceptance.
  task automatic run_load(input logic [2:0] f3, input logic [31:0] addr,
                          input logic [4:0] rd, input int waits, input int err_beat,
                          input logic [31:0] w0, input logic [31:0] w1);
    int wait_cnt;
    r_beats = 0; r_cycle = -1; r_addr0 = '0; r_addr1 = '0;
    r_data = '0; r_fault = 1'b0; r_rd = '0;
    wait_cnt = 0;
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = f3; req_addr = addr; req_rd = rd;
    @(negedge clk);
    req_valid = 1'b0; req_funct3 = '0; req_addr = '0; req_rd = '0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = '0;
      if (rsp_valid) begin
        r_cycle = cyc; r_data = rsp_data; r_fault = rsp_fault; r_rd = rsp_rd;
        break;
      end
      if (mem_req) begin
        if (wait_cnt == waits) begin
          if (r_beats == 0) r_addr0 = mem_addr;
          else              r_addr1 = mem_addr;
          mem_ack   = 1'b1;
          mem_rdata = (r_beats == 0) ? w0 : w1;
          mem_err   = (err_beat == r_beats);
          r_beats++;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
      @(negedge clk);
    end
    checks++;
    if (r_cycle < 0) begin
      errors++;
      $display("[TB] FAIL rsp_timeout: got no rsp_valid within 30 cycles, required a response");
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready: got %b required 1", req_ready); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_req: got %b required 0", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_addr: got %h required 0", mem_addr); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b required 0", rsp_valid); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_rsp_data: got %h required 0", rsp_data); end
    checks++; if (rsp_rd !== 5'd0) begin errors++; $display("[TB] FAIL reset_rsp_rd: got %0d required 0", rsp_rd); end
    checks++; if (rsp_fault !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_fault: got %b required 0", rsp_fault); end
    checks++; if (w_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_w_req_ready: got %b required 1", w_req_ready); end
  endtask

  task automatic test_lw();
    run_load(OP_LW, 32'h8, 5'd5, 0, -1, 32'hA5A5A5A5, 32'h0);
    checks++; if (r_addr0 !== 32'h8) begin errors++; $display("[TB] FAIL lw_mem_addr: got %h required 00000008", r_addr0); end
    checks++; if (r_data !== 32'hA5A5A5A5) begin errors++; $display("[TB] FAIL lw_data: got %h required a5a5a5a5", r_data); end
    checks++; if (r_fault !== 1'b0) begin errors++; $display("[TB] FAIL lw_fault: got %b required 0", r_fault); end
    checks++; if (r_cycle != 2) begin errors++; $display("[TB] FAIL lw_latency: got cycle %0d required 2", r_cycle); end
    checks++; if (r_rd !== 5'd5) begin errors++; $display("[TB] FAIL lw_rd: got %0d required 5", r_rd); end
  endtask

  task automatic test_byte_half();
    run_load(OP_LB, 32'h9, 5'd1, 0, -1, 32'h00008000, 32'h0);
    checks++; if (r_data !== 32'hFFFFFF80) begin errors++; $display("[TB] FAIL lb_data: got %h required ffffff80", r_data); end
    run_load(OP_LBU, 32'h9, 5'd2, 2, -1, 32'h00008000, 32'h0);
    checks++; if (r_data !== 32'h00000080) begin errors++; $display("[TB] FAIL lbu_data: got %h required 00000080", r_data); end
    checks++; if (r_cycle != 4) begin errors++; $display("[TB] FAIL lbu_wait_latency: got cycle %0d required 4", r_cycle); end
    run_load(OP_LHU, 32'hA, 5'd3, 0, -1, 32'hFFFF0000, 32'h0);
    checks++; if (r_data !== 32'h0000FFFF) begin errors++; $display("[TB] FAIL lhu_data: got %h required 0000ffff", r_data); end
    checks++; if (r_addr0 !== 32'h8) begin errors++; $display("[TB] FAIL lhu_mem_addr: got %h required 00000008", r_addr0); end
    run_load(OP_LH, 32'hA, 5'd4, 0, -1, 32'hFFFF0000, 32'h0);
    checks++; if (r_data !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL lh_data: got %h required ffffffff", r_data); end
  endtask

  task automatic test_misalign();
    run_load(OP_LH, 32'hB, 5'd6, 0, -1, 32'hAABBCCDD, 32'h11223344);
`ifdef LOAD_MISALIGN_EN
    checks++; if (r_beats != 2) begin errors++; $display("[TB] FAIL cross_beats: got %0d required 2", r_beats); end
    checks++; if (r_addr1 !== 32'hC) begin errors++; $display("[TB] FAIL cross_addr1: got %h required 0000000c", r_addr1); end
    checks++; if (r_data !== 32'h000044AA) begin errors++; $display("[TB] FAIL cross_data: got %h required 000044aa", r_data); end
    checks++; if (r_cycle != 3) begin errors++; $display("[TB] FAIL cross_latency: got cycle %0d required 3", r_cycle); end
    run_load(OP_LH, 32'h9, 5'd7, 0, -1, 32'h00ABCD00, 32'h0);
    checks++; if (r_data !== 32'hFFFFABCD || r_beats != 1) begin errors++; $display("[TB] FAIL misal_single: got %h beats %0d required ffffabcd beats 1", r_data, r_beats); end
    run_load(OP_LW, 32'hFFFFFFFE, 5'd8, 0, -1, 32'h11223344, 32'h55667788);
    checks++; if (r_addr1 !== 32'h0) begin errors++; $display("[TB] FAIL wrap_addr1: got %h required 00000000", r_addr1); end
    checks++; if (r_data !== 32'h77881122) begin errors++; $display("[TB] FAIL wrap_data: got %h required 77881122", r_data); end
`else
    checks++; if (r_fault !== 1'b1) begin errors++; $display("[TB] FAIL misal_fault: got %b required 1", r_fault); end
    checks++; if (r_data !== 32'h0) begin errors++; $display("[TB] FAIL misal_data: got %h required 0", r_data); end
    checks++; if (r_beats != 0) begin errors++; $display("[TB] FAIL misal_no_mem: got %0d beats required 0", r_beats); end
    checks++; if (r_cycle != 1) begin errors++; $display("[TB] FAIL misal_latency: got cycle %0d required 1", r_cycle); end
    run_load(OP_LW, 32'h4 + 32'h2, 5'd7, 0, -1, 32'h12345678, 32'h0);
    checks++; if (r_fault !== 1'b1 || r_beats != 0) begin errors++; $display("[TB] FAIL misal_lw: got fault %b beats %0d required fault 1 beats 0", r_fault, r_beats); end
`endif
  endtask

  task automatic test_illegal();
    run_load(3'b011, 32'h10, 5'd9, 0, -1, 32'hDEADBEEF, 32'h0);
    checks++; if (r_fault !== 1'b1) begin errors++; $display("[TB] FAIL ld32_fault: got %b required 1", r_fault); end
    checks++; if (r_cycle != 1) begin errors++; $display("[TB] FAIL ld32_latency: got cycle %0d required 1", r_cycle); end
    checks++; if (r_beats != 0) begin errors++; $display("[TB] FAIL ld32_no_mem: got %0d beats required 0", r_beats); end
    checks++; if (r_data !== 32'h0 || r_rd !== 5'd9) begin errors++; $display("[TB] FAIL ld32_resp: got data %h rd %0d required 0 rd 9", r_data, r_rd); end
    run_load(3'b111, 32'h0, 5'd10, 0, -1, 32'hDEADBEEF, 32'h0);
    checks++; if (r_fault !== 1'b1 || r_beats != 0) begin errors++; $display("[TB] FAIL f3_111: got fault %b beats %0d required fault 1 beats 0", r_fault, r_beats); end
  endtask

  task automatic test_bus_error();
    run_load(OP_LW, 32'h10, 5'd11, 0, 0, 32'hCAFEF00D, 32'h0);
    checks++; if (r_fault !== 1'b1 || r_data !== 32'h0) begin errors++; $display("[TB] FAIL buserr: got fault %b data %h required fault 1 data 0", r_fault, r_data); end
`ifdef LOAD_MISALIGN_EN
    run_load(OP_LW, 32'hE, 5'd12, 0, 0, 32'hCAFEF00D, 32'h12345678);
    checks++; if (r_fault !== 1'b1 || r_beats != 1 || r_cycle != 2) begin errors++; $display("[TB] FAIL buserr_cross: got fault %b beats %0d cycle %0d required fault 1 beats 1 cycle 2", r_fault, r_beats, r_cycle); end
`endif
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = OP_LW; req_addr = 32'h20; req_rd = 5'd13;
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_req_before: got %b required 1", mem_req); end
    #2 reset = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_async_drop: got %b required 0", mem_req); end
    @(negedge clk);
    reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h55555555; mem_err = 1'b0;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = '0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_req_ready: got %b required 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_late_ack: got rsp_valid %b mem_req %b required 0 0", rsp_valid, mem_req); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = OP_LW; req_addr = 32'h4; req_rd = 5'd7;
    @(negedge clk);
    req_valid = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h12345678; mem_err = 1'b0;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = '0;
    // A second request is offered during RESP and must not be taken
    req_valid = 1'b1; req_funct3 = OP_LB; req_addr = 32'h40; req_rd = 5'd20;
    for (int i = 0; i < 3; i++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h12345678 || rsp_rd !== 5'd7) begin errors++; $display("[TB] FAIL stall_hold: cycle %0d got valid %b data %h rd %0d required 1 12345678 7", i, rsp_valid, rsp_data, rsp_rd); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_req_ready: cycle %0d got %b required 0", i, req_ready); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("[TB] FAIL stall_release: got valid %b ready %b required 0 1", rsp_valid, req_ready); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_no_accept: got mem_req %b required 0", mem_req); end
  endtask

  task automatic test_xlen64();
    @(negedge clk);
    w_req_valid = 1'b1; w_req_funct3 = OP_LD; w_req_addr = 32'h10; w_req_rd = 5'd14;
    @(negedge clk);
    w_req_valid = 1'b0;
    checks++; if (w_mem_req !== 1'b1 || w_mem_addr !== 32'h10) begin errors++; $display("[TB] FAIL ld64_mem: got req %b addr %h required 1 00000010", w_mem_req, w_mem_addr); end
    w_mem_ack = 1'b1; w_mem_rdata = 64'h8000000000000001;
    @(negedge clk);
    w_mem_ack = 1'b0; w_mem_rdata = '0;
    checks++; if (w_rsp_valid !== 1'b1 || w_rsp_data !== 64'h8000000000000001) begin errors++; $display("[TB] FAIL ld64_data: got valid %b data %h required 1 8000000000000001", w_rsp_valid, w_rsp_data); end
    checks++; if (w_rsp_fault !== 1'b0 || w_rsp_rd !== 5'd14) begin errors++; $display("[TB] FAIL ld64_fault: got fault %b rd %0d required 0 14", w_rsp_fault, w_rsp_rd); end
    w_rsp_ready = 1'b1;
    @(negedge clk);
    w_rsp_ready = 1'b0;
  endtask

  // Hard limit in case the design never returns control to a task
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_funct3 = '0; req_addr = '0; req_rd = '0;
    mem_ack = 1'b0; mem_rdata = '0; mem_err = 1'b0; rsp_ready = 1'b0;
    w_req_valid = 1'b0; w_req_funct3 = '0; w_req_addr = '0; w_req_rd = '0;
    w_mem_ack = 1'b0; w_mem_rdata = '0; w_mem_err = 1'b0; w_rsp_ready = 1'b0;
    test_reset();
    test_lw();
    test_byte_half();
    test_misalign();
    test_illegal();
    test_bus_error();
    test_back_to_back();
    test_xlen64();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
